// File: rtl/instr_fetch_queue_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, word size, and the
// {pc, instr} queue entry.
package instr_fetch_queue_pkg;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] INSTR_NOP  = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Instruction-memory read port plus the queue-head handshake toward IF/ID.
// master = fetch queue, slave = memory/consumer side.
interface instr_fetch_queue_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    modport master (
        output imem_req, imem_addr, valid, instr, pc, pc_plus4,
        input  imem_rvalid, imem_rdata, ready
    );

    modport slave (
        input  imem_req, imem_addr, valid, instr, pc, pc_plus4,
        output imem_rvalid, imem_rdata, ready
    );

endinterface

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Purpose: DEPTH-entry {pc, instr} queue with synchronous flush.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pushes while full and pops while empty are dropped.
module fetch_fifo
    import instr_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    output fetch_entry_t head_dat,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);

    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Flush wins over any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Purpose: owns fetch PC, issues one-outstanding imem reads, queues {pc, instr} for IF/ID.
// Latency: start->req 1 cycle; response->valid 1 cycle; redirect->new req 1 cycle.
// Backpressure: ready=0 lets the queue fill to DEPTH, after which requests stop.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    instr_fetch_queue_if.master bus
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [AW:0]  count;
    logic [AW:0]  count_after;
    logic         full;
    logic         empty;
    logic         flush;
    logic         push;
    logic         pop;
    logic         issue;
    fetch_entry_t head_dat;
    fetch_entry_t push_dat;

    assign flush       = redirect_valid && (state != ST_IDLE);
    assign push        = (state == ST_WAIT) && bus.imem_rvalid && !redirect_valid;
    assign pop         = !empty && bus.ready;
    assign count_after = count + (AW+1)'(push) - (AW+1)'(pop);
    // fetch_pc has already stepped past the outstanding request.
    assign push_dat    = '{pc: fetch_pc - 32'(WORD_BYTES), instr: bus.imem_rdata};

    always_comb begin
        issue = 1'b0;
        if (!rst && !redirect_valid) begin
            case (state)
                ST_ISSUE: issue = !full;
                ST_WAIT:  issue = bus.imem_rvalid && (count_after < DEPTH_CNT);
                default:  issue = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
        end else if (state == ST_IDLE) begin
            if (start) state <= ST_ISSUE;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            // A read still in flight must be drained before the next one goes out.
            if ((state == ST_WAIT || state == ST_DISCARD) && !bus.imem_rvalid)
                state <= ST_DISCARD;
            else
                state <= ST_ISSUE;
        end else begin
            if (issue) fetch_pc <= fetch_pc + 32'(WORD_BYTES);
            case (state)
                ST_ISSUE:   if (issue) state <= ST_WAIT;
                ST_WAIT:    if (bus.imem_rvalid && !issue) state <= ST_ISSUE;
                ST_DISCARD: if (bus.imem_rvalid) state <= ST_ISSUE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.valid     = !empty;
    assign bus.instr     = empty ? INSTR_NOP : head_dat.instr;
    assign bus.pc        = empty ? 32'h0 : head_dat.pc;
    assign bus.pc_plus4  = empty ? 32'h0 : head_dat.pc + 32'(WORD_BYTES);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a flag/queue reference model.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Shadow inputs, applied to the DUT at the next falling edge.
    logic        s_rst, s_start, s_redir, s_ready;
    logic [31:0] s_rpc;
    bit          stray, redir_on_rv, chk_en;

    // Reference model: active / outstanding / stale flags plus an entry queue.
    bit          m_active, m_out, m_stale;
    logic [31:0] m_fetch_pc, m_req_addr;
    logic [63:0] m_q[$];

    // Memory responder.
    bit          mem_pend;
    int          mem_cnt, mem_lat;
    logic [31:0] mem_addr_q;

    logic [31:0] pop_log[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h2008_0005 : ((a ^ 32'h5A5A_0000) + 32'h13);
    endfunction

    task automatic m_reset();
        m_active   = 0;
        m_out      = 0;
        m_stale    = 0;
        m_fetch_pc = RESET_PC;
        m_q.delete();
    endtask

    task automatic cycle();
        bit          rv, exp_req, pop;
        int          n;
        logic [31:0] e_pc, e_instr;
        @(negedge clk);
        rst = s_rst; start = s_start; redirect_valid = s_redir;
        redirect_pc = s_rpc; bus.ready = s_ready;
        rv = 0;
        if (mem_pend) begin
            if (mem_cnt <= 1) begin rv = 1; mem_pend = 0; end
            else mem_cnt--;
        end
        bus.imem_rdata = rv ? mem_word(mem_addr_q) : $urandom;
        if (stray) rv = 1;
        stray = 0;
        bus.imem_rvalid = rv;
        if (redir_on_rv) begin
            redirect_valid = rv && (m_q.size() > 0);
            redirect_pc    = 32'h0000_1000;
        end
        #1;
        n       = m_q.size();
        pop     = (n > 0) && bus.ready;
        exp_req = !rst && m_active && !redirect_valid &&
                  ((!m_out && n < DEPTH) ||
                   (m_out && !m_stale && rv && (n + 1 - (pop ? 1 : 0)) < DEPTH));
        e_pc    = (n > 0) ? m_q[0][63:32] : 32'h0;
        e_instr = (n > 0) ? m_q[0][31:0]  : 32'h0;
        if (chk_en) begin
            chk("imem_req",  32'(bus.imem_req), 32'(exp_req));
            chk("imem_addr", bus.imem_addr, m_fetch_pc);
            chk("valid",     32'(bus.valid), 32'(n > 0));
            chk("instr",     bus.instr, e_instr);
            chk("pc",        bus.pc, e_pc);
            chk("pc_plus4",  bus.pc_plus4, (n > 0) ? e_pc + 32'd4 : 32'h0);
        end
        if (pop) pop_log.push_back(bus.pc);
        if (bus.imem_req) begin
            mem_pend = 1; mem_cnt = mem_lat; mem_addr_q = bus.imem_addr;
        end
        if (rst) m_reset();
        else if (!m_active) begin
            if (start) m_active = 1;
        end else if (redirect_valid) begin
            m_q.delete();
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
            if (m_out && !rv) m_stale = 1;
            else begin m_out = 0; m_stale = 0; end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_out && rv) begin
                if (!m_stale) m_q.push_back({m_req_addr, bus.imem_rdata});
                m_out = 0; m_stale = 0;
            end
            if (exp_req) begin
                m_out = 1; m_req_addr = m_fetch_pc; m_fetch_pc += 32'd4;
            end
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        s_rst = 1; cycle(); s_rst = 0;
        repeat (8) if (mem_pend) cycle();
    endtask

    initial begin
        bit f;
        rst = 1; start = 0; redirect_valid = 0; redirect_pc = 0;
        bus.ready = 0; bus.imem_rvalid = 0; bus.imem_rdata = 0;
        s_rst = 1; s_start = 0; s_redir = 0; s_rpc = 0; s_ready = 0;
        stray = 0; redir_on_rv = 0; chk_en = 0; mem_pend = 0; mem_lat = 1;
        m_reset();

        cycle(); chk_en = 1; cycle(); s_rst = 0;
        #2;
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_addr",  bus.imem_addr, RESET_PC);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_pc4",   bus.pc_plus4, 32'h0);

        // First fetch, then fill with ready held low.
        s_start = 1; cycle(); s_start = 0; cycle(); cycle();
        #2;
        chk("first_valid", 32'(bus.valid), 32'h1);
        chk("first_instr", bus.instr, 32'h2008_0005);
        chk("first_pc",    bus.pc, 32'h0);
        chk("first_pc4",   bus.pc_plus4, 32'h4);
        repeat (6) cycle();
        #2;
        chk("full_no_req", 32'(bus.imem_req), 32'h0);
        chk("full_addr",   bus.imem_addr, 32'h10);
        pop_log.delete();
        s_ready = 1;
        repeat (12) cycle();
        for (int i = 0; i < 5; i++)
            chk("drain_order", (i < pop_log.size()) ? pop_log[i] : 32'hFFFF_FFFF, 32'(i * 4));

        // Redirect with three entries queued and nothing outstanding.
        do_reset();
        s_ready = 0; s_start = 1; cycle(); s_start = 0;
        repeat (8) cycle();
        s_ready = 1; cycle(); s_ready = 0;
        s_redir = 1; s_rpc = 32'h43; cycle(); s_redir = 0;
        #2;
        chk("redir_valid", 32'(bus.valid), 32'h0);
        chk("redir_addr",  bus.imem_addr, 32'h40);

        // Redirect while a latency-3 read is in flight.
        mem_lat = 3; s_ready = 1;
        cycle(); cycle();
        pop_log.delete();
        s_redir = 1; s_rpc = 32'h200; cycle(); s_redir = 0;
        repeat (8) cycle();
        f = 0;
        foreach (pop_log[i]) if (pop_log[i] == 32'h40) f = 1;
        chk("stale_dropped",  32'(f), 32'h0);
        chk("redir_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hFFFF_FFFF, 32'h200);

        // Redirect coinciding with a response and a pop.
        mem_lat = 1; s_ready = 1; redir_on_rv = 1;
        repeat (30) cycle();
        redir_on_rv = 0;

        // Reset mid-read, then stray responses while idle.
        do_reset();
        mem_lat = 3; s_start = 1; cycle(); s_start = 0; cycle(); cycle();
        s_rst = 1; cycle(); s_rst = 0;
        #2;
        chk("midrst_valid", 32'(bus.valid), 32'h0);
        chk("midrst_addr",  bus.imem_addr, RESET_PC);
        repeat (6) cycle();
        stray = 1; cycle(); cycle();
        #2;
        chk("stray_no_req",   32'(bus.imem_req), 32'h0);
        chk("stray_no_valid", 32'(bus.valid), 32'h0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            s_ready = ($urandom_range(0, 3) != 0);
            s_rst   = ($urandom_range(0, 299) == 0);
            s_start = !s_rst && !m_active && !mem_pend && ($urandom_range(0, 3) == 0);
            s_redir = ($urandom_range(0, 19) == 0);
            s_rpc   = $urandom_range(0, 1) ? $urandom : 32'hFFFF_FFF0 + $urandom_range(0, 15);
            mem_lat = $urandom_range(1, 4);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
